// File: rtl/hazard_stall_unit.sv
// Hazard/stall unit: tracks EX/MEM/WB destination tags for the forwarding block,
// inserts load-use bubbles, freezes on slow loads and counts lost cycles.
module hazard_stall_unit #(
  parameter int RA_W     = 4,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_wr,
  input  logic             id_load,
  input  logic             mem_ready,
  input  logic             flush,
  output logic             stall,
  output logic             freeze,
  output logic [RA_W-1:0]  emrd,
  output logic [RA_W-1:0]  mwrd,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic            valid;
    logic            wr;
    logic            load;
    logic [RA_W-1:0] rd;
  } slot_t;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  localparam slot_t           BUBBLE_C   = {(RA_W+3){1'b0}};
  localparam logic [RA_W-1:0] TAG0_C     = {RA_W{1'b0}};
  localparam logic [7:0]      WAIT_MAX_C = 8'(WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT_C = {CNT_W{1'b1}};

  slot_t            ex_r, mem_r, wb_r;
  slot_t            ex_nxt_s, mem_nxt_s, wb_nxt_s, id_slot_s;
  logic             freeze_s, ld_use_s, stall_s, rs_hit_s, rt_hit_s;
  logic [RA_W-1:0]  emrd_r, mwrd_r;
  logic             err_r;
  logic [7:0]       wait_cnt_r, wait_inc_s;
  state_t           state_r;
  logic [CNT_W-1:0] stall_cnt_r;

  // Hazard detection: a slow load in MEM outranks a load-use bubble.
  always_comb begin
    freeze_s = mem_r.valid & mem_r.load & ~mem_ready;
    rs_hit_s = id_use_rs & (id_rs == ex_r.rd);
    rt_hit_s = id_use_rt & (id_rt == ex_r.rd);
    ld_use_s = id_valid & ex_r.valid & ex_r.load & ex_r.wr & (ex_r.rd != TAG0_C)
               & (rs_hit_s | rt_hit_s);
    stall_s  = ld_use_s & ~freeze_s;
  end

  // ID fields as they would enter EX.
  always_comb begin
    if (id_valid) begin
      id_slot_s = '{valid: 1'b1, wr: id_wr, load: id_load, rd: id_rd};
    end else begin
      id_slot_s = BUBBLE_C;
    end
  end

  // Next-slot selection: freeze holds everything, stall/flush inject a bubble.
  always_comb begin
    ex_nxt_s  = ex_r;
    mem_nxt_s = mem_r;
    wb_nxt_s  = wb_r;
    if (freeze_s) begin
      ex_nxt_s  = ex_r;
      mem_nxt_s = mem_r;
      wb_nxt_s  = wb_r;
    end else if (stall_s || flush) begin
      ex_nxt_s  = BUBBLE_C;
      mem_nxt_s = ex_r;
      wb_nxt_s  = mem_r;
    end else begin
      ex_nxt_s  = id_slot_s;
      mem_nxt_s = ex_r;
      wb_nxt_s  = mem_r;
    end
  end

  // Slot registers and forwarding tags, which track the slots edge for edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_r   <= BUBBLE_C;
      mem_r  <= BUBBLE_C;
      wb_r   <= BUBBLE_C;
      emrd_r <= TAG0_C;
      mwrd_r <= TAG0_C;
    end else begin
      ex_r   <= ex_nxt_s;
      mem_r  <= mem_nxt_s;
      wb_r   <= wb_nxt_s;
      emrd_r <= mem_nxt_s.wr ? mem_nxt_s.rd : TAG0_C;
      mwrd_r <= wb_nxt_s.wr ? wb_nxt_s.rd : TAG0_C;
    end
  end

  // Saturating increment of the memory wait counter.
  always_comb begin
    if (wait_cnt_r >= WAIT_MAX_C) begin
      wait_inc_s = WAIT_MAX_C;
    end else begin
      wait_inc_s = wait_cnt_r + 8'd1;
    end
  end

  // Memory-wait FSM with sticky timeout flag; the timeout never releases the freeze.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_RUN;
      wait_cnt_r <= 8'd0;
      err_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          wait_cnt_r <= 8'd0;
          state_r    <= freeze_s ? ST_MEM_WAIT : ST_RUN;
        end
        ST_MEM_WAIT: begin
          if (freeze_s) begin
            wait_cnt_r <= wait_inc_s;
            if (wait_inc_s == WAIT_MAX_C) begin
              err_r <= 1'b1;
            end else begin
              err_r <= err_r;
            end
          end else begin
            wait_cnt_r <= 8'd0;
            state_r    <= ST_RUN;
          end
        end
        default: begin
          wait_cnt_r <= 8'd0;
          state_r    <= ST_RUN;
        end
      endcase
    end
  end

  // Performance counter of cycles lost to stall or freeze.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if ((stall_s || freeze_s) && (stall_cnt_r != CNT_SAT_C)) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall     = stall_s;
  assign freeze    = freeze_s;
  assign emrd      = emrd_r;
  assign mwrd      = mwrd_r;
  assign err       = err_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed scenarios plus random traffic, checked
// against an in-flight instruction list model through a scoreboard queue.
module tb_hazard_stall_unit;
  localparam int RA_W     = 4;
  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 6;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, id_valid, id_use_rs, id_use_rt, id_wr, id_load, mem_ready, flush;
  logic [RA_W-1:0] id_rs, id_rt, id_rd;
  logic            stall, freeze, err;
  logic [RA_W-1:0] emrd, mwrd;
  logic [CNT_W-1:0] stall_cnt;

  hazard_stall_unit #(.RA_W(RA_W), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_wr(id_wr),
    .id_load(id_load), .mem_ready(mem_ready), .flush(flush), .stall(stall),
    .freeze(freeze), .emrd(emrd), .mwrd(mwrd), .err(err), .stall_cnt(stall_cnt)
  );

  typedef struct { bit valid; bit wr; bit load; int rd; } ins_t;
  typedef struct { bit stall; bit freeze; bit err; int emrd; int mwrd; int cnt; } exp_t;

  ins_t pipe[$];   // in-flight instructions, [0]=EX, [1]=MEM, [2]=WB
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  bit   m_err;
  int   m_run, m_cnt;

  function automatic ins_t nop();
    ins_t n;
    n.valid = 1'b0; n.wr = 1'b0; n.load = 1'b0; n.rd = 0;
    return n;
  endfunction

  task automatic model_reset();
    pipe.delete();
    repeat (3) pipe.push_back(nop());
    m_err = 1'b0; m_run = 0; m_cnt = 0;
  endtask

  function automatic bit m_freeze();
    return pipe[1].valid && pipe[1].load && !mem_ready;
  endfunction

  function automatic bit m_lduse();
    int d = pipe[0].rd;
    return id_valid && pipe[0].valid && pipe[0].load && pipe[0].wr && d != 0 &&
           ((id_use_rs && int'(id_rs) == d) || (id_use_rt && int'(id_rt) == d));
  endfunction

  task automatic model_step();
    bit fr, st;
    ins_t n;
    if (reset) begin
      model_reset();
    end else begin
      fr = m_freeze();
      st = m_lduse() && !fr;
      if (st || fr) m_cnt = (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
      if (fr) begin
        m_run++;
        if (m_run > WAIT_MAX) m_err = 1'b1;
      end else begin
        m_run = 0;
        n = nop();
        if (id_valid && !st && !flush) begin
          n.valid = 1'b1; n.wr = id_wr; n.load = id_load; n.rd = int'(id_rd);
        end
        void'(pipe.pop_back());
        pipe.push_front(n);
      end
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [3:0] rs, input logic [3:0] rt,
                       input logic urs, input logic urt, input logic [3:0] rd, input logic wr,
                       input logic ld, input logic rdy, input logic fl);
    exp_t e;
    reset = r; id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_rd = rd; id_wr = wr; id_load = ld; mem_ready = rdy; flush = fl;
    e.freeze = m_freeze();
    e.stall  = m_lduse() && !e.freeze;
    e.emrd   = pipe[1].wr ? pipe[1].rd : 0;
    e.mwrd   = pipe[2].wr ? pipe[2].rd : 0;
    e.err    = m_err;
    e.cnt    = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic nops(input int n, input logic rdy);
    repeat (n) cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("stall", int'(stall), int'(e.stall));
      chk("freeze", int'(freeze), int'(e.freeze));
      chk("emrd", int'(emrd), e.emrd);
      chk("mwrd", int'(mwrd), e.mwrd);
      chk("err", int'(err), int'(e.err));
      chk("stall_cnt", int'(stall_cnt), e.cnt);
    end
  end

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_rs = 4'd0; id_rt = 4'd0; id_use_rs = 1'b0;
    id_use_rt = 1'b0; id_rd = 4'd0; id_wr = 1'b0; id_load = 1'b0; mem_ready = 1'b1; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    nops(2, 1'b1);
    // load-use on r8, ID held for the repeat
    cycle(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 4'd8, 4'd0, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 4'd8, 4'd0, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    nops(3, 1'b1);
    // load rA, consumer reads rB only
    cycle(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd10, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 4'd11, 4'd11, 1'b1, 1'b1, 4'd12, 1'b1, 1'b0, 1'b1, 1'b0);
    nops(3, 1'b1);
    // short memory wait
    cycle(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    nops(1, 1'b1);
    nops(3, 1'b0);
    nops(3, 1'b1);
    // long memory wait hits the timeout, then reset clears it
    cycle(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd6, 1'b1, 1'b1, 1'b1, 1'b0);
    nops(1, 1'b1);
    nops(20, 1'b0);
    nops(2, 1'b1);
    cycle(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    nops(2, 1'b1);
    // load into r0 is never a hazard
    cycle(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    nops(3, 1'b1);
    // flush coincident with a load-use hazard
    cycle(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 4'd3, 4'd0, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 4'd3, 4'd0, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    nops(3, 1'b1);
    // reset during freeze
    cycle(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    nops(1, 1'b1);
    nops(2, 1'b0);
    cycle(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    nops(2, 1'b1);
    // random traffic over a small register set to provoke frequent hazards
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 9) == 0));
    end
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
